// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, scanner FSM states and the row/column-to-code map.
package keypad_pkg;

    typedef enum logic [3:0] {
        KC_0, KC_1, KC_2, KC_3, KC_4, KC_5, KC_6, KC_7, KC_8, KC_9,
        KC_STOP, KC_START, KC_NONE = 4'd15
    } key_code_t;

    typedef enum logic [2:0] {S_IDLE, S_DEBOUNCE, S_EMIT, S_HELD, S_RELEASE} state_t;

    // Rows 0..2 carry digits 1..9; row 3 is STOP 0 START.
    function automatic logic [3:0] kc_map(input logic [1:0] row, input logic [1:0] col);
        if (row != 2'd3)
            return 4'(row) * 4'd3 + 4'(col) + 4'd1;
        return (col == 2'd0) ? KC_STOP : (col == 2'd1) ? KC_0 : KC_START;
    endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// keypad_row_scan: rotates the row drive, samples columns at the end of each
// row slot and resolves one key code per frame (NONE for no key or ghosting).
module keypad_row_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] frame_code,
    output logic       frame_done
);
    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    row_q, row_d, acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic [2:0]    low, sum;
    logic [1:0]    hits, first_col, tot;
    logic [3:0]    code_here;
    logic          sample;

    assign row_n = ~(4'b0001 << row_q);

    // acc_cnt saturates at 2: any second key in a frame marks it ghosted.
    always_comb begin
        low        = ~col_n;
        hits       = {1'b0, low[0]} + {1'b0, low[1]} + {1'b0, low[2]};
        first_col  = low[0] ? 2'd0 : low[1] ? 2'd1 : 2'd2;
        sum        = {1'b0, acc_cnt_q} + {1'b0, hits};
        tot        = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        code_here  = (acc_cnt_q == 2'd0) ? kc_map(row_q, first_col) : acc_code_q;
        sample     = div_q == DW'(SCAN_DIV - 1);
        frame_done = sample && row_q == 2'd3;
        frame_code = (tot == 2'd1) ? code_here : KC_NONE;
        div_d      = sample ? '0 : div_q + 1'b1;
        row_d      = sample ? row_q + 2'd1 : row_q;
        acc_cnt_d  = !sample ? acc_cnt_q : frame_done ? 2'd0 : tot;
        acc_code_d = !sample ? acc_code_q : frame_done ? KC_NONE : code_here;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            div_q      <= '0;
            row_q      <= '0;
            acc_cnt_q  <= '0;
            acc_code_q <= KC_NONE;
        end else begin
            div_q      <= div_d;
            row_q      <= row_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 keypad scanner with debounce and one-cycle panel pulses.
// Define KEYPAD_REPEAT_EN to enable digit auto-repeat every REPEAT_FRAMES frames.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 4,
    parameter int DEBOUNCE      = 3
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_FRAMES = 8
`endif
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] key,
    output logic       startn,
    output logic       stopn
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d, frame_code;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [9:0]    key_q, key_d;
    logic          startn_q, startn_d, stopn_q, stopn_d, frame_done;
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    logic [RW-1:0] rep_q, rep_d, rep_inc;
`endif

    keypad_row_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clock     (clock),
        .clear     (clear),
        .col_n     (col_n),
        .row_n     (row_n),
        .frame_code(frame_code),
        .frame_done(frame_done)
    );

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        cnt_inc  = cnt_q + 1'b1;
        key_d    = '0;
        startn_d = 1'b1;
        stopn_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
        rep_d    = rep_q;
        rep_inc  = rep_q + 1'b1;
`endif
        case (state_q)
            S_IDLE:
                if (frame_done && frame_code != KC_NONE) begin
                    cand_d  = frame_code;
                    cnt_d   = CW'(1);
                    state_d = (DEBOUNCE == 1) ? S_EMIT : S_DEBOUNCE;
                end
            S_DEBOUNCE:
                if (frame_done) begin
                    if (frame_code == cand_q) begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == CW'(DEBOUNCE)) ? S_EMIT : S_DEBOUNCE;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        cand_d  = KC_NONE;
                    end
                end
            S_EMIT: begin
                state_d = S_HELD;
                cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                rep_d   = '0;
`endif
            end
            S_HELD:
                if (frame_done) begin
                    if (frame_code == KC_NONE) begin
                        state_d = (DEBOUNCE == 1) ? S_IDLE : S_RELEASE;
                        cnt_d   = (DEBOUNCE == 1) ? '0 : CW'(1);
                        cand_d  = (DEBOUNCE == 1) ? KC_NONE : cand_q;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (cand_q <= KC_9) begin
                        rep_d   = rep_inc;
                        state_d = (rep_inc == RW'(REPEAT_FRAMES)) ? S_EMIT : S_HELD;
                    end
`endif
                end
            S_RELEASE:
                if (frame_done) begin
                    if (frame_code == KC_NONE) begin
                        cnt_d   = (cnt_inc == CW'(DEBOUNCE)) ? '0 : cnt_inc;
                        state_d = (cnt_inc == CW'(DEBOUNCE)) ? S_IDLE : S_RELEASE;
                        cand_d  = (cnt_inc == CW'(DEBOUNCE)) ? KC_NONE : cand_q;
                    end else begin
                        state_d = S_HELD;
                        cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = '0;
`endif
                    end
                end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered on the edge that enters EMIT, so the pulse
        // occupies exactly the EMIT cycle.
        if (state_d == S_EMIT) begin
            key_d    = (cand_d <= KC_9) ? 10'(1) << cand_d : '0;
            startn_d = cand_d != KC_START;
            stopn_d  = cand_d != KC_STOP;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= S_IDLE;
            cand_q   <= KC_NONE;
            cnt_q    <= '0;
            key_q    <= '0;
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            startn_q <= startn_d;
            stopn_q  <= stopn_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end

    assign key    = key_q;
    assign startn = startn_q;
    assign stopn  = stopn_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad presses with a pulse scoreboard; expected
// pulses carry the cycle on which they must appear.
module tb_keypad_scanner;
    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] key;
    logic       startn, stopn;

    always #5 clock = ~clock;

    keypad_scanner dut (
        .clock (clock),
        .clear (clear),
        .col_n (col_n),
        .row_n (row_n),
        .key   (key),
        .startn(startn),
        .stopn (stopn)
    );

    // Physical keypad: a held key shorts its column low while its row is driven.
    logic [3:0][2:0] held = '0;
    always_comb begin
        col_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (held[r][c] && !row_n[r]) col_n[c] = 1'b0;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] key;
        logic       startn;
        logic       stopn;
        int         cyc;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int rc, fr, nvec, nerr;

    // Pulse expected right after boundary fr+frames (16-cycle frames from rc).
    task automatic expect_at(input logic [9:0] k, input logic sn, input logic pn, input int frames);
        exp_t x;
        x.key = k; x.startn = sn; x.stopn = pn; x.cyc = rc + 16 * (fr + frames);
        q.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, want, cyc);
        end
    endtask

    task automatic adv(input int n);
        repeat (16 * n) @(negedge clock);
        fr += n;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " row_n"}, 32'(row_n), 32'b1110);
        check({tag, " key"}, 32'(key), 32'd0);
        check({tag, " startn"}, 32'(startn), 32'd1);
        check({tag, " stopn"}, 32'(stopn), 32'd1);
    endtask

    initial begin
        nvec = 0; nerr = 0; fr = 0; rc = 0;
        fork
            forever begin
                @(negedge clock);
                if (!clear && (key !== '0 || startn !== 1'b1 || stopn !== 1'b1)) begin
                    nvec++;
                    if (q.size() == 0) begin
                        nerr++;
                        $display("FAIL unexpected pulse: got key=%b startn=%b stopn=%b at cyc %0d, want no pulse",
                                 key, startn, stopn, cyc);
                    end else begin
                        e = q.pop_front();
                        if (key !== e.key || startn !== e.startn || stopn !== e.stopn || cyc != e.cyc) begin
                            nerr++;
                            $display("FAIL pulse: got key=%b startn=%b stopn=%b cyc=%0d, want key=%b startn=%b stopn=%b cyc=%0d",
                                     key, startn, stopn, cyc, e.key, e.startn, e.stopn, e.cyc);
                        end
                    end
                end
            end
        join_none

        // Reset and scan timing
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_vals("reset");
        clear = 1'b0;
        rc = cyc;
        repeat (3) @(negedge clock);
        check("row_n slot0 end", 32'(row_n), 32'b1110);
        @(negedge clock);
        check("row_n slot1", 32'(row_n), 32'b1101);
        repeat (12) @(negedge clock);
        fr = 1;

        // Digit 5 held 10 frames, released, pressed again
        held[1][1] = 1'b1;
        expect_at(10'b0000100000, 1'b1, 1'b1, 3);
        adv(10);
        held = '0;
        adv(5);
        held[1][1] = 1'b1;
        expect_at(10'b0000100000, 1'b1, 1'b1, 3);
        adv(4);
        held = '0;
        adv(4);

        // Digit 4 bouncing every frame, then held
        for (int i = 0; i < 12; i++) begin
            held[1][0] = (i % 2 == 0);
            adv(1);
        end
        held[1][0] = 1'b1;
        expect_at(10'b0000010000, 1'b1, 1'b1, 3);
        adv(3);
        held = '0;
        adv(4);

        // STOP and START
        held[3][0] = 1'b1;
        expect_at(10'b0, 1'b1, 1'b0, 3);
        adv(5);
        held = '0;
        adv(4);
        held[3][2] = 1'b1;
        expect_at(10'b0, 1'b0, 1'b1, 3);
        adv(5);
        held = '0;
        adv(4);

        // Ghosting: same row, then same column
        held[0][0] = 1'b1;
        held[0][1] = 1'b1;
        adv(6);
        held = '0;
        adv(2);
        held[0][2] = 1'b1;
        held[2][2] = 1'b1;
        adv(6);
        held = '0;
        adv(2);

        // Long hold of digit 0 (repeats only when enabled), then START
        held[3][1] = 1'b1;
        expect_at(10'b0000000001, 1'b1, 1'b1, 3);
`ifdef KEYPAD_REPEAT_EN
        expect_at(10'b0000000001, 1'b1, 1'b1, 11);
        expect_at(10'b0000000001, 1'b1, 1'b1, 19);
        expect_at(10'b0000000001, 1'b1, 1'b1, 27);
`endif
        adv(30);
        held = '0;
        adv(4);
        held[3][2] = 1'b1;
        expect_at(10'b0, 1'b0, 1'b1, 3);
        adv(30);
        held = '0;
        adv(4);

        // Digit 0 held 2 frames then clear: pending press dropped, re-debounced from reset
        held[3][1] = 1'b1;
        adv(2);
        clear = 1'b1;
        @(negedge clock);
        check_reset_vals("mid clear");
        clear = 1'b0;
        rc = cyc;
        fr = 0;
        expect_at(10'b0000000001, 1'b1, 1'b1, 3);
        adv(5);
        held = '0;
        adv(4);

        check("pending pulses", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end for the microwave controller: scans a 4×3 active-low keypad, debounces presses and converts each accepted press into the panel inputs that `nivel1` consumes. It drives a one-cycle one-hot pulse on `key[9:0]` for digit keys and a one-cycle low pulse on `startn` / `stopn`. It sits between the board keypad pins and `nivel1`, on the same `clock`.

## Interface
- `SCAN_DIV`, default 4: clock cycles each row stays driven; must be ≥ 2.
- `DEBOUNCE`, default 3: consecutive identical scan frames required to accept a press or a release; must be ≥ 1.
- `REPEAT_FRAMES`, default 8: auto-repeat period in frames. Used only when `KEYPAD_REPEAT_EN` is defined.
- `clock` input, 1 bit: sole clock, rising edge.
- `clear` input, 1 bit: synchronous, active-high reset.
- `col_n` input, 3 bits: keypad columns, active low. Already synchronised externally.
- `row_n` output, 4 bits: keypad row drive, exactly one bit low at a time.
- `key` output, 10 bits: one-hot digit pulse; `key[i]` is digit i.
- `startn` output, 1 bit: active-low start pulse.
- `stopn` output, 1 bit: active-low stop pulse.

## Operation
- Keypad map:
  - row0 = 1 2 3
  - row1 = 4 5 6
  - row2 = 7 8 9
  - row3 = STOP 0 START
  - Columns are listed left to right as `col_n[0..2]`.
- Row scan:
  - `row_n` rotates 1110 → 1101 → 1011 → 0111 → 1110, advancing every `SCAN_DIV` cycles.
  - `col_n` is sampled on the last cycle of each row slot.
- Frame:
  - One frame = 4 row slots = 4·`SCAN_DIV` cycles.
  - At the frame boundary (the edge that takes the row3 sample), the frame code is resolved:
    - NONE if no column was seen low.
    - The key code if exactly one key was seen.
    - NONE if two or more keys were seen (ghosting is rejected).
- FSM states: IDLE, DEBOUNCE, EMIT, HELD, RELEASE.
  - IDLE: a non-NONE frame code → DEBOUNCE, latch the candidate code, count = 1.
  - DEBOUNCE:
    - Frame equals candidate: count + 1.
    - Frame differs (including NONE): back to IDLE and discard the candidate.
    - Count reaches `DEBOUNCE`: → EMIT.
    - With `DEBOUNCE` = 1, IDLE goes straight to EMIT.
  - EMIT: lasts one cycle and drives the output pulse for the candidate → HELD.
  - HELD:
    - A NONE frame → RELEASE with count = 1.
    - A frame holding a different single key does not emit anything.
  - RELEASE:
    - `DEBOUNCE` consecutive NONE frames → IDLE.
    - Any non-NONE frame → HELD.
- Output encoding:
  - Digit d gives `key` = 1<<d.
  - START gives `startn` = 0.
  - STOP gives `stopn` = 0.
  - At most one output is active in any cycle.
- The scan counter runs continuously in every state.

## Timing
- Reset values, applied by `clear` on the next edge:
  - `row_n` = 4'b1110
  - `key` = 0
  - `startn` = 1, `stopn` = 1
  - state IDLE; scan, debounce and repeat counters all 0
- `clear` asserted mid-operation drops any pending or held press. No pulse is emitted at or after reset until a new press is debounced.
- Latency: the pulse is high during the cycle after the frame boundary at which the count reaches `DEBOUNCE`.
  - For a press stable from the start of frame k, the pulse follows the boundary of frame k+`DEBOUNCE`−1.
- Pulse width is exactly 1 cycle.
- Repeated presses need a debounced release between them.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a digit key held for `REPEAT_FRAMES` further frames re-emits one pulse, then repeats every `REPEAT_FRAMES` frames.
  - The repeat counter resets on entry to HELD.
  - START and STOP never repeat.
- `KEYPAD_REPEAT_EN` undefined:
  - Exactly one pulse per press.
  - The repeat counter and `REPEAT_FRAMES` logic are absent.

## Structure
- Package `keypad_pkg` holds:
  - Key-code constants: KC_0..KC_9 = 0..9, KC_STOP = 10, KC_START = 11, KC_NONE = 15 (4-bit).
  - The FSM state encoding.
  - The row/column-to-code map function.
- One sub-module, `keypad_row_scan`: owns the row rotation, column sampling and frame-code resolution. It outputs `frame_code[3:0]` plus a one-cycle `frame_done` strobe.
- The top level holds the debounce/emit FSM and output registers.

## Test plan
Parameters are at their defaults unless stated: frame = 16 cycles.
- Reset: assert `clear` for 2 cycles → `row_n` = 1110, `key` = 0, `startn` = `stopn` = 1. `row_n` = 1101 exactly 4 cycles after `clear` deasserts.
- Digit press: hold row1/col1 (digit 5) for 10 frames → `key` = 10'b0000100000 for exactly one cycle, following the 3rd frame boundary. No further pulse; release 5 frames, press again → a second single pulse.
- Bounce: toggle digit 4 every frame for 12 frames → no pulse. Then hold 3 frames → `key` = 10'b0000010000 once.
- Control keys:
  - STOP (row3/col0) held → `stopn` = 0 for one cycle.
  - START (row3/col2) held → `startn` = 0 for one cycle.
  - `key` stays 0 throughout.
- Ghost and reset:
  - Digits 1 and 2 held together → no output.
  - Digit 0 held 2 frames, then `clear` pulsed → no pulse, and state returns to the reset values.
- Repeat (`KEYPAD_REPEAT_EN`, `REPEAT_FRAMES` = 8):
  - Hold digit 0 for 30 frames → pulses after frames 3, 11, 19 and 27.
  - Hold START for 30 frames → one pulse only.
